haze_window_stat: RTL and testbench

HAZE_WINDOW_STAT -- requirements
Module: haze_window_stat

---
 rtl/haze_window_stat.sv | 129 ++++++++++++
 tb/tb_haze_window_stat.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/haze_window_stat.sv
// haze_window_stat: windowed mean/max/min/over-threshold statistics
// over 2^n haze samples, with a sticky over-count alarm.
module haze_window_stat #(
  parameter real TCQ          = 0.1,
  parameter int  DATA_WIDTH   = 16,
  parameter int  WIN_LOG2_MAX = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic                    haze_vld_i,
  input  logic [DATA_WIDTH-1:0]   haze_data_i,
  input  logic [3:0]              win_log2_i,
  input  logic [DATA_WIDTH-1:0]   thresh_i,
  input  logic [WIN_LOG2_MAX:0]   alarm_cnt_i,
  output logic                    stat_vld_o,
  output logic [DATA_WIDTH-1:0]   stat_mean_o,
  output logic [DATA_WIDTH-1:0]   stat_max_o,
  output logic [DATA_WIDTH-1:0]   stat_min_o,
  output logic [WIN_LOG2_MAX:0]   stat_over_o,
  output logic                    alarm_o
);

  localparam int CW = WIN_LOG2_MAX + 1;
  localparam int SW = DATA_WIDTH + WIN_LOG2_MAX;
  localparam logic [3:0] NMAX = 4'(WIN_LOG2_MAX);

  // TCQ is a simulation timing hint only; registers carry no delay.
  if (TCQ < 0.0) begin : g_tcq_neg
  end

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [CW-1:0]         cnt;
  logic [3:0]            n_lat;
  logic [SW-1:0]         sum;
  logic [DATA_WIDTH-1:0] mx;
  logic [DATA_WIDTH-1:0] mn;
  logic [CW-1:0]         over;

  logic [3:0]            n_clamp;
  logic [3:0]            n_eff;
  logic [CW-1:0]         win_len;
  logic [CW-1:0]         cnt_new;
  logic [SW-1:0]         sum_new;
  logic [DATA_WIDTH-1:0] mx_new;
  logic [DATA_WIDTH-1:0] mn_new;
  logic [CW-1:0]         over_new;
  logic [DATA_WIDTH-1:0] mean_new;
  logic                  accept;
  logic                  restart;
  logic                  last;
  logic                  alarm_hit;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (en_i && !clear_i) state_nx = RUN;
      RUN:  if (!en_i) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nx;
  end

  // n is taken live on the first sample, then from the latch.
  always_comb begin
    n_clamp   = (win_log2_i > NMAX) ? NMAX : win_log2_i;
    n_eff     = (cnt == '0) ? n_clamp : n_lat;
    win_len   = CW'(1) << n_eff;
    cnt_new   = cnt + CW'(1);
    last      = (cnt_new == win_len);
    sum_new   = sum + SW'(haze_data_i);
    mx_new    = (haze_data_i > mx) ? haze_data_i : mx;
    mn_new    = (haze_data_i < mn) ? haze_data_i : mn;
    over_new  = over + CW'(haze_data_i > thresh_i);
    mean_new  = DATA_WIDTH'(sum_new >> n_eff);
    accept    = (state == RUN) && haze_vld_i && !clear_i;
    restart   = clear_i || (state == IDLE);
    alarm_hit = (alarm_cnt_i != '0) && (over_new >= alarm_cnt_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt         <= '0;
      n_lat       <= '0;
      sum         <= '0;
      mx          <= '0;
      mn          <= '1;
      over        <= '0;
      stat_vld_o  <= 1'b0;
      stat_mean_o <= '0;
      stat_max_o  <= '0;
      stat_min_o  <= '0;
      stat_over_o <= '0;
      alarm_o     <= 1'b0;
    end else begin
      stat_vld_o <= 1'b0;
      if (clear_i) alarm_o <= 1'b0;
      if (restart || (accept && last)) begin
        cnt  <= '0;
        sum  <= '0;
        mx   <= '0;
        mn   <= '1;
        over <= '0;
      end else if (accept) begin
        cnt  <= cnt_new;
        sum  <= sum_new;
        mx   <= mx_new;
        mn   <= mn_new;
        over <= over_new;
      end
      if (accept && cnt == '0) n_lat <= n_clamp;
      if (accept && last) begin
        stat_vld_o  <= 1'b1;
        stat_mean_o <= mean_new;
        stat_max_o  <= mx_new;
        stat_min_o  <= mn_new;
        stat_over_o <= over_new;
        if (alarm_hit) alarm_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_haze_window_stat.sv
// tb_haze_window_stat: table vectors plus corner sequences, with
// expected window results queued at drive time and popped per pulse.
module tb_haze_window_stat;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic        vld;
  logic [15:0] data;
  logic [3:0]  win;
  logic [15:0] thresh;
  logic [10:0] alarm_cnt;
  logic        stat_vld;
  logic [15:0] stat_mean;
  logic [15:0] stat_max;
  logic [15:0] stat_min;
  logic [10:0] stat_over;
  logic        alarm;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] mean;
    logic [15:0] mx;
    logic [15:0] mn;
    logic [10:0] over;
  } exp_t;

  typedef struct {
    logic [3:0]       n;
    logic [15:0]      thr;
    logic [3:0][15:0] d;
    exp_t             e;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];

  haze_window_stat dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .clear_i     (clr),
    .haze_vld_i  (vld),
    .haze_data_i (data),
    .win_log2_i  (win),
    .thresh_i    (thresh),
    .alarm_cnt_i (alarm_cnt),
    .stat_vld_o  (stat_vld),
    .stat_mean_o (stat_mean),
    .stat_max_o  (stat_max),
    .stat_min_o  (stat_min),
    .stat_over_o (stat_over),
    .alarm_o     (alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d,
                      input logic c);
    vld  = v;
    data = d;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk_e(input logic [15:0] mean,
                                input logic [15:0] mx,
                                input logic [15:0] mn,
                                input logic [10:0] over);
    exp_t e;
    e.mean = mean;
    e.mx   = mx;
    e.mn   = mn;
    e.over = over;
    return e;
  endfunction

  function automatic vec_t mk_v(input logic [3:0] n,
                                input logic [15:0] thr,
                                input logic [15:0] d0, d1, d2, d3,
                                input exp_t e);
    vec_t v;
    v.n    = n;
    v.thr  = thr;
    v.d[0] = d0;
    v.d[1] = d1;
    v.d[2] = d2;
    v.d[3] = d3;
    v.e    = e;
    return v;
  endfunction

  always @(negedge clk) begin
    if (stat_vld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mean", stat_mean, e.mean);
        check("max",  stat_max,  e.mx);
        check("min",  stat_min,  e.mn);
        check("over", stat_over, e.over);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_vld"},   stat_vld,  0);
    check({tag, "_mean"},  stat_mean, 0);
    check({tag, "_max"},   stat_max,  0);
    check({tag, "_min"},   stat_min,  0);
    check({tag, "_over"},  stat_over, 0);
    check({tag, "_alarm"}, alarm,     0);
  endtask

  initial begin
    vecs[0] = mk_v(4'd0, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0,
                   mk_e(16'd4, 16'd4, 16'd4, 11'd1));
    vecs[1] = mk_v(4'd1, 16'd15, 16'd10, 16'd20, 16'd0, 16'd0,
                   mk_e(16'd15, 16'd20, 16'd10, 11'd1));
    vecs[2] = mk_v(4'd2, 16'd99, 16'd0, 16'hFFFF, 16'd100, 16'd3,
                   mk_e(16'd16409, 16'hFFFF, 16'd0, 11'd2));
    vecs[3] = mk_v(4'd2, 16'd7, 16'd7, 16'd7, 16'd7, 16'd8,
                   mk_e(16'd7, 16'd8, 16'd7, 11'd1));
    vecs[4] = mk_v(4'd1, 16'hFFFF, 16'd1, 16'd2, 16'd0, 16'd0,
                   mk_e(16'd1, 16'd2, 16'd1, 11'd0));

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; vld = 1'b0;
    data = '0; win = 4'd2; thresh = '0; alarm_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    en    = 1'b1;
    step(0, 0, 0);

    // mean/max/min/over with sparse strobes, alarm set
    win = 4'd2; thresh = 16'd5; alarm_cnt = 11'd2;
    step(1, 1, 0); step(0, 0, 0);
    step(1, 9, 0); step(0, 0, 0);
    step(1, 3, 0); step(0, 0, 0);
    exp_q.push_back(mk_e(16'd5, 16'd9, 16'd1, 11'd2));
    step(1, 7, 0); step(0, 0, 0);
    check("alarm_set", alarm, 1);

    // clear coincident with sample 2 restarts window, drops alarm
    step(1, 3, 0);
    step(1, 6, 1);
    check("alarm_cleared", alarm, 0);
    check("hold_after_clear", stat_mean, 5);
    exp_q.push_back(mk_e(16'd2, 16'd2, 16'd2, 11'd0));
    repeat (4) step(1, 2, 0);
    step(0, 0, 0);
    check("alarm_stays_clear", alarm, 0);

    // table rows run back-to-back across window boundaries
    alarm_cnt = '0;
    for (int r = 0; r < 5; r++) begin
      win    = vecs[r].n;
      thresh = vecs[r].thr;
      exp_q.push_back(vecs[r].e);
      for (int k = 0; k < (1 << vecs[r].n); k++)
        step(1, vecs[r].d[k], 0);
    end
    step(0, 0, 0);

    // full-scale 1024-sample window
    win = 4'd10; thresh = '0;
    exp_q.push_back(mk_e(16'hFFFF, 16'hFFFF, 16'hFFFF, 11'd1024));
    repeat (1024) step(1, 16'hFFFF, 0);
    step(0, 0, 0);

    // mid-window n change, then n=15 clamped to 10
    win = 4'd2;
    exp_q.push_back(mk_e(16'd2, 16'd4, 16'd1, 11'd4));
    step(1, 1, 0); step(1, 2, 0);
    win = 4'd3;
    step(1, 3, 0); step(1, 4, 0);
    exp_q.push_back(mk_e(16'd4, 16'd8, 16'd1, 11'd8));
    for (int i = 1; i <= 8; i++) step(1, 16'(i), 0);
    win = 4'd15;
    exp_q.push_back(mk_e(16'd511, 16'd1023, 16'd0, 11'd1023));
    for (int i = 0; i < 1024; i++) step(1, 16'(i), 0);
    step(0, 0, 0);

    // n=0, back-to-back single-sample windows
    win = 4'd0; thresh = 16'd5;
    exp_q.push_back(mk_e(16'd4, 16'd4, 16'd4, 11'd0));
    exp_q.push_back(mk_e(16'd8, 16'd8, 16'd8, 11'd1));
    step(1, 4, 0);
    step(1, 8, 0);
    step(0, 0, 0);

    // enable drop discards the partial window
    win = 4'd2; thresh = '0;
    step(1, 3, 0); step(1, 3, 0);
    en = 1'b0;
    step(0, 0, 0);
    check("hold_after_disable", stat_mean, 8);
    en = 1'b1;
    step(0, 0, 0);
    exp_q.push_back(mk_e(16'd5, 16'd5, 16'd5, 11'd4));
    repeat (4) step(1, 5, 0);
    step(0, 0, 0);

    // async reset after 3 of 4 samples
    thresh = 16'd5;
    repeat (3) step(1, 9, 0);
    vld   = 1'b0;
    rst_n = 1'b0;
    #2;
    check_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0);
    exp_q.push_back(mk_e(16'd1, 16'd1, 16'd1, 11'd0));
    repeat (4) step(1, 1, 0);
    repeat (3) step(0, 0, 0);

    check("missing_pulse", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
